// File: rtl/dram_scan_pkg.sv
// rtl/dram_scan_pkg.sv - shared types, defaults and helpers for the data-memory series scanner
//
// Contents:
//   scan_state_t  : scanner FSM states
//   bswap32       : 32-bit byte reversal (memory image is big-endian w.r.t. the bus)
//   IDX_W         : word index width, enough for 4096 words
//   DEFAULT_*     : default series parameters and scan length
package dram_scan_pkg;

  localparam int          IDX_W              = 12;
  localparam int          DEFAULT_WORD_COUNT = 15;
  localparam logic [31:0] DEFAULT_INIT_VAL   = 32'h1234_5678;
  localparam logic [31:0] DEFAULT_STEP_VAL   = 32'hDCBA_1234;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/dram_scan_seq_gen.sv
// rtl/dram_scan_seq_gen.sv - word index counter and series accumulator
//
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   load         : restart at index 0 / INIT_VAL (wins over advance)
//   advance      : step to the next word, accumulator += STEP_VAL (mod 2^32)
//   idx          : current word index
//   exp_val      : series value for idx, before byte reversal
//   last         : idx is the final word (WORD_COUNT-1)
module dram_scan_seq_gen
  import dram_scan_pkg::*;
#(
  parameter int          WORD_COUNT = DEFAULT_WORD_COUNT,
  parameter logic [31:0] INIT_VAL   = DEFAULT_INIT_VAL,
  parameter logic [31:0] STEP_VAL   = DEFAULT_STEP_VAL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic [31:0]      exp_val,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx     <= '0;
      exp_val <= INIT_VAL;
    end else if (load) begin
      idx     <= '0;
      exp_val <= INIT_VAL;
    end else if (advance) begin
      idx     <= idx + 1'b1;
      exp_val <= exp_val + STEP_VAL;
    end
  end

  assign last = (idx == LAST_IDX);

endmodule

// File: rtl/dram_series_scanner.sv
// rtl/dram_series_scanner.sv - data-memory bus initiator that checks a byte-reversed arithmetic series
//
// Optional feature macro: DRAM_SCAN_WRITE_EN (write the image before reading it back).
//
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   start                        : scan request, honoured only in IDLE
//   data_address/_read/_write    : word-aligned byte address and strobes to memory
//   data_writedata               : bswap(series) during writes, otherwise 0
//   data_readdata                : combinational read data, sampled at the end of each read cycle
//   busy                         : scan in progress
//   done, pass                   : last scan finished / no mismatches (held until next start)
//   err_count                    : mismatches, saturating at 255
//   first_err_addr               : byte address of the first mismatch, 0 if none
module dram_series_scanner
  import dram_scan_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WORD_COUNT = DEFAULT_WORD_COUNT,
  parameter logic [31:0] INIT_VAL   = DEFAULT_INIT_VAL,
  parameter logic [31:0] STEP_VAL   = DEFAULT_STEP_VAL
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [31:0] first_err_addr
);

  scan_state_t      state, state_nxt;
  logic             seq_load, seq_adv, seq_last;
  logic [IDX_W-1:0] idx;
  logic [31:0]      exp_val;
  logic [31:0]      word_addr;
  logic             mismatch;

  dram_scan_seq_gen #(
    .WORD_COUNT (WORD_COUNT),
    .INIT_VAL   (INIT_VAL),
    .STEP_VAL   (STEP_VAL)
  ) u_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (seq_load),
    .advance (seq_adv),
    .idx     (idx),
    .exp_val (exp_val),
    .last    (seq_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Reloading on the last write lets the read pass restart the series
  // without an extra IDLE cycle between the two passes.
  always_comb begin
    state_nxt = state;
    seq_load  = 1'b0;
    seq_adv   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          seq_load  = 1'b1;
`ifdef DRAM_SCAN_WRITE_EN
          state_nxt = ST_WRITE;
`else
          state_nxt = ST_READ;
`endif
        end
      end
`ifdef DRAM_SCAN_WRITE_EN
      ST_WRITE: begin
        seq_adv = 1'b1;
        if (seq_last) begin
          seq_load  = 1'b1;
          state_nxt = ST_READ;
        end
      end
`endif
      ST_READ: begin
        seq_adv = 1'b1;
        if (seq_last) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign word_addr = BASE_ADDR + {{(30 - IDX_W){1'b0}}, idx, 2'b00};
  assign busy      = (state != ST_IDLE);
  assign data_read = (state == ST_READ);

`ifdef DRAM_SCAN_WRITE_EN
  assign data_write     = (state == ST_WRITE);
  assign data_writedata = (state == ST_WRITE) ? bswap32(exp_val) : 32'h0;
  assign data_address   = (state == ST_WRITE || state == ST_READ) ? word_addr : 32'h0;
`else
  assign data_write     = 1'b0;
  assign data_writedata = 32'h0;
  assign data_address   = (state == ST_READ) ? word_addr : 32'h0;
`endif

  assign mismatch = (data_readdata != bswap32(exp_val));

  // err_count saturates and never returns to 0 mid-scan, so a zero count
  // marks "no mismatch seen yet" even when the first failing address is 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 8'd0;
      first_err_addr <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            done           <= 1'b0;
            err_count      <= 8'd0;
            first_err_addr <= 32'h0;
          end
        end
        ST_READ: begin
          if (mismatch) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (err_count == 8'd0)  first_err_addr <= word_addr;
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          pass <= (err_count == 8'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_series_scanner.sv
// tb/tb_dram_series_scanner.sv - self-checking bench for dram_series_scanner
module tb_dram_series_scanner;

  localparam logic [31:0] INIT  = 32'h1234_5678;
  localparam logic [31:0] STEP  = 32'hDCBA_1234;
  localparam int          WC0   = 15;
  localparam int          WC1   = 300;
  localparam logic [31:0] BASE1 = 32'h0000_0400;

`ifdef DRAM_SCAN_WRITE_EN
  localparam int EXP_LAT    = 2 * WC0 + 2;
  localparam int EXP_WRITES = WC0;
`else
  localparam int EXP_LAT    = WC0 + 2;
  localparam int EXP_WRITES = 0;
`endif

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start0, start1;
  logic [31:0] addr0, wd0, rdata0, addr1, wd1, rdata1;
  logic        wr0, rd0, busy0, done0, pass0;
  logic        wr1, rd1, busy1, done1, pass1;
  logic [7:0]  err0, err1;
  logic [31:0] first0, first1;

  logic [31:0] mem0 [0:15];
  logic [31:0] mem1 [0:511];
  logic [31:0] off1;

  assign rdata0 = mem0[addr0[5:2]];
  assign off1   = addr1 - BASE1;
  assign rdata1 = mem1[off1[10:2]];

  always @(posedge clk) begin
    if (wr0) mem0[addr0[5:2]] <= wd0;
    if (wr1) mem1[off1[10:2]] <= wd1;
  end

  dram_series_scanner #(.BASE_ADDR(32'h0), .WORD_COUNT(WC0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .data_address(addr0), .data_write(wr0), .data_read(rd0),
    .data_writedata(wd0), .data_readdata(rdata0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_addr(first0)
  );

  dram_series_scanner #(.BASE_ADDR(BASE1), .WORD_COUNT(WC1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .data_address(addr1), .data_write(wr1), .data_read(rd1),
    .data_writedata(wd1), .data_readdata(rdata1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_addr(first1)
  );

  // Series word k as it must appear in memory, computed directly.
  function automatic logic [31:0] ref_word(input int k);
    logic [31:0] v;
    v = INIT + 32'(k) * STEP;
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_series();
    for (int k = 0; k < 16; k++) mem0[k] = ref_word(k);
  endtask

  // Expected result from the image the read pass will see.
  task automatic model_expect(output logic [7:0] e_err, output logic [31:0] e_first,
                              output logic e_pass);
    logic [31:0] img [0:15];
    int bad[$];
    for (int k = 0; k < WC0; k++) begin
`ifdef DRAM_SCAN_WRITE_EN
      img[k] = ref_word(k);
`else
      img[k] = mem0[k];
`endif
      if (img[k] !== ref_word(k)) bad.push_back(k);
    end
    e_err   = (bad.size() > 255) ? 8'hFF : 8'(bad.size());
    e_first = (bad.size() > 0) ? 32'(4 * bad[0]) : 32'h0;
    e_pass  = (bad.size() == 0);
  endtask

  task automatic run_scan0(input bit hold, output int n_reads, output int n_writes,
                           output int latency, output logic [31:0] wdata4,
                           output bit bus_ok, output logic first_busy,
                           output logic first_done);
    int cyc;
    n_reads = 0; n_writes = 0; latency = -1; wdata4 = 32'hx; bus_ok = 1'b1;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk);
    if (!hold) start0 = 1'b0;
    first_busy = busy0;
    first_done = done0;
    for (cyc = 1; cyc <= 1000; cyc++) begin
      if (rd0 && wr0) bus_ok = 1'b0;
      if (rd0) begin
        if (addr0 !== 32'(4 * n_reads)) bus_ok = 1'b0;
        n_reads++;
      end
      if (wr0) begin
        if (addr0 !== 32'(4 * n_writes)) bus_ok = 1'b0;
        if (addr0 === 32'h4) wdata4 = wd0;
        n_writes++;
      end
      if (done0) begin
        latency = cyc;
        start0  = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  task automatic scan_and_check(input string tag, input bit hold);
    int nr, nw, lat;
    logic [31:0] w4, e_first;
    logic [7:0] e_err;
    logic e_pass, fb, fd;
    bit ok;
    model_expect(e_err, e_first, e_pass);
    run_scan0(hold, nr, nw, lat, w4, ok, fb, fd);
    check({tag, "_reads"}, 32'(nr), 32'(WC0));
    check({tag, "_writes"}, 32'(nw), 32'(EXP_WRITES));
    check({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
    check({tag, "_bus_seq"}, 32'(ok), 32'd1);
    check({tag, "_busy_first"}, 32'(fb), 32'd1);
    check({tag, "_done_cleared"}, 32'(fd), 32'd0);
    check({tag, "_done"}, 32'(done0), 32'd1);
    check({tag, "_pass"}, 32'(pass0), 32'(e_pass));
    check({tag, "_err_count"}, 32'(err0), 32'(e_err));
    check({tag, "_first_err"}, first0, e_first);
  endtask

  task automatic check_idle_outputs0(input string tag);
    check({tag, "_busy"}, 32'(busy0), 32'd0);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_pass"}, 32'(pass0), 32'd0);
    check({tag, "_err"}, 32'(err0), 32'd0);
    check({tag, "_first"}, first0, 32'h0);
    check({tag, "_read"}, 32'(rd0), 32'd0);
    check({tag, "_write"}, 32'(wr0), 32'd0);
    check({tag, "_addr"}, addr0, 32'h0);
  endtask

  initial begin
    int quiet, found, n;
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    load_series();
    for (int k = 0; k < 512; k++) mem1[k] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs0("reset");
    check("reset_busy1", 32'(busy1), 32'd0);
    check("reset_done1", 32'(done1), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean preloaded image
    scan_and_check("clean", 1'b0);

    // Words at 0x8 and 0x20 zeroed
    load_series();
    mem0[2] = 32'h0;
    mem0[8] = 32'h0;
    scan_and_check("two_bad", 1'b0);

    // Randomized corruption
    for (int t = 0; t < 5; t++) begin
      load_series();
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) begin
        int k;
        k = $urandom_range(0, WC0 - 1);
        mem0[k] = mem0[k] ^ ($urandom() | 32'h1);
      end
      scan_and_check($sformatf("rand%0d", t), 1'b0);
    end

    // start held high for the whole scan: exactly one scan
    load_series();
    scan_and_check("hold", 1'b1);
    quiet = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rd0 || wr0 || busy0) quiet++;
    end
    check("hold_no_rescan", 32'(quiet), 32'd0);
    check("hold_done_held", 32'(done0), 32'd1);

    // New start while done=1 clears done and rescans
    scan_and_check("rescan", 1'b0);

    // Reset during the read of word 7, with a mismatch already counted
    load_series();
    mem0[2] = 32'hDEAD_BEEF;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (rd0 && addr0 === 32'h1C) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("midreset_reached_word7", 32'(found), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs0("midreset");
    reset_n = 1'b1;
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd0 || wr0 || busy0) quiet++;
    end
    check("midreset_quiet", 32'(quiet), 32'd0);

`ifdef DRAM_SCAN_WRITE_EN
    // Zeroed memory: the scan writes the image, then verifies it
    begin
      int nr, nw, lat;
      logic [31:0] w4;
      logic fb, fd;
      bit ok;
      for (int k = 0; k < 16; k++) mem0[k] = 32'h0;
      run_scan0(1'b0, nr, nw, lat, w4, ok, fb, fd);
      check("wr_data_at_4", w4, 32'hAC68_EEEE);
      check("wr_pass", 32'(pass0), 32'd1);
      check("wr_err", 32'(err0), 32'd0);
      check("wr_mem_word2", mem0[2], 32'hE07A_A8CB);
    end
`endif

    // Long scan against zeroed memory on the second instance
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      if (done1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("long_done", 32'(found), 32'd1);
`ifdef DRAM_SCAN_WRITE_EN
    check("long_err", 32'(err1), 32'd0);
    check("long_first", first1, 32'h0);
    check("long_pass", 32'(pass1), 32'd1);
`else
    check("long_err_saturated", 32'(err1), 32'd255);
    check("long_first", first1, BASE1);
    check("long_pass", 32'(pass1), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_series_scanner.md
# dram_series_scanner

Bus initiator for the CPU-side data-memory port (word address, read/write strobes, combinational read, single-cycle write). On `start` it walks a block of consecutive words and compares each against an arithmetic series stored big-endian, i.e. byte-reversed relative to the bus value. It reports pass/fail, an error count and the first failing address. It sits in the test harness in place of the CPU, to qualify data-memory models and preload images before core tests run.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be word-aligned.
- `WORD_COUNT`, 15: number of words scanned; legal range 1..4096.
- `INIT_VAL`, 32'h1234_5678: series value for word 0, before byte reversal.
- `STEP_VAL`, 32'hDCBA_1234: series difference, added modulo 2^32.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a scan.
- `data_address`  out  32: byte address driven to memory.
- `data_write`  out  1: write strobe.
- `data_read`  out  1: read strobe.
- `data_writedata`  out  32: write data.
- `data_readdata`  in  32: combinational read data, valid in the same cycle as `data_read`.
- `busy`  out  1: scan in progress.
- `done`  out  1: last scan finished; held until the next accepted `start`.
- `pass`  out  1: valid while `done`=1; 1 means no mismatches.
- `err_count`  out  8: mismatch count; saturates at 255.
- `first_err_addr`  out  32: byte address of the first mismatch; 0 if there was none.

## Operation
- States: IDLE, WRITE (only with the macro), READ, DONE.
- IDLE:
  - Strobes are low and `data_address` is 0.
  - `start`=1 clears `err_count`, `first_err_addr` and `done`, loads index 0 and accumulator `INIT_VAL`.
  - Then goes to WRITE if the macro is defined, otherwise to READ.
- An index k and an accumulator exp_k = INIT_VAL + k·STEP_VAL are maintained. The accumulator adds STEP_VAL each word; no multiplier is used.
- The memory image of word k is bswap(exp_k): bytes [7:0]↔[31:24] and [15:8]↔[23:16].
- READ, one word per cycle:
  - Drives `data_read`=1, `data_write`=0 and `data_address`=BASE_ADDR+4k.
  - `data_readdata` is sampled at the closing edge.
  - On mismatch against bswap(exp_k), `err_count` increments (saturating). The first mismatch also latches `first_err_addr`.
  - After word WORD_COUNT−1, goes to DONE.
- DONE lasts one cycle:
  - Sets `done`=1.
  - Sets `pass`=(err_count==0), computed after the final word has been counted.
  - Then returns to IDLE. `done` and the results hold in IDLE.
- `busy`=1 in WRITE, READ and DONE.
- `start` is ignored outside IDLE.
- Both strobes are never high in the same cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `data_readdata` to any output.

## Timing
- `start` sampled at edge N. The first bus cycle is N→N+1, with `busy`=1 from N+1.
- Scan without the macro: READ covers cycles N+1..N+WORD_COUNT. DONE is the cycle after that, and `done` rises one edge later.
- Scan with the macro: WORD_COUNT write cycles, then WORD_COUNT read cycles.
- Reset, checked at every edge, including mid-scan:
  - Go to IDLE.
  - Clear all outputs: `busy`, `done`, `pass`, `err_count`, `first_err_addr`, strobes and address all 0.
  - No further bus cycle follows. A partially written image is left as-is.
- Reset has priority over `start` in the same cycle.
- Index wraps never occur: the terminal index is WORD_COUNT−1. The accumulator wraps modulo 2^32.

## Configuration
- `DRAM_SCAN_WRITE_EN` defined:
  - The WRITE state is compiled in.
  - Each write cycle drives `data_write`=1, `data_read`=0, `data_address`=BASE_ADDR+4k and `data_writedata`=bswap(exp_k).
  - After WORD_COUNT writes, the index and accumulator reload and the scan enters READ.
- Not defined: the WRITE state is absent, `data_write` is tied 0 and `data_writedata` is tied 0. The block only verifies a preloaded image.

## Structure
- Package `dram_scan_pkg`:
  - State enum.
  - `bswap32` function.
  - Default constants for `INIT_VAL`, `STEP_VAL` and `WORD_COUNT`.
- Sub-module `dram_scan_seq_gen`: index counter plus accumulator, with load, advance and last-word flag. The FSM, bus drive and checker live in the top module.

## Test plan
- Memory preloaded with the 15-word default series, `start` pulse → 15 read cycles at addresses 0x0..0x38. Word 1 must read 32'hAC68EEEE and word 2 32'hE07AA8CB. Result: `done`=1, `pass`=1, `err_count`=0, `first_err_addr`=0.
- Same image with words at 0x8 and 0x20 overwritten to 0 → `pass`=0, `err_count`=2, `first_err_addr`=32'h8.
- `start` held high through the whole scan → exactly one scan. A new `start` while `done`=1 clears `done` and rescans.
- `reset_n` low during the read of word 7 → at the next edge all outputs are 0. No strobe afterwards until a new `start`.
- With `DRAM_SCAN_WRITE_EN`, zeroed memory, `start` → the write at address 0x4 carries 32'hAC68EEEE. The following read pass gives `pass`=1.
- `WORD_COUNT`=300 against zeroed memory, macro off → `err_count`=255 (saturated), `first_err_addr`=BASE_ADDR.
